// File: rtl/neuron_seq.sv
// Sequencer for one neuron MACC: walks input/weight BRAMs per neuron, aligns
// en/last to BRAM read latency, and hands each result out over valid/ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start, MACC held in reset
// ISSUE    | one beat address per cycle for the current neuron
// WAIT_ACC | beats draining through the BRAM pipe, waiting on macc_valid
// OUTPUT   | result held on dout until the consumer accepts it
module neuron_seq #(
    parameter int PARALLEL_IN  = 4,
    parameter int DATA1_WIDTH  = 16,
    parameter int DATA2_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int NEURON_WIDTH = 6,
    parameter int BRAM_LAT     = 2,
    parameter int DOUT_WIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                n_words,
    input  logic [NEURON_WIDTH-1:0]              n_neurons,
    output logic                                 busy,
    output logic                                 done,
    output logic [ADDR_WIDTH-1:0]                in_addr,
    output logic [NEURON_WIDTH+ADDR_WIDTH-1:0]   w_addr,
    input  logic [PARALLEL_IN*DATA1_WIDTH-1:0]   in_data,
    input  logic [PARALLEL_IN*DATA2_WIDTH-1:0]   w_data,
    output logic [PARALLEL_IN*DATA1_WIDTH-1:0]   macc_din1,
    output logic [PARALLEL_IN*DATA2_WIDTH-1:0]   macc_din2,
    output logic                                 macc_en,
    output logic                                 macc_last,
    output logic                                 macc_rst,
    input  logic [DOUT_WIDTH-1:0]                macc_dout,
    input  logic                                 macc_valid,
    output logic [DOUT_WIDTH-1:0]                dout,
    output logic [NEURON_WIDTH-1:0]              dout_neuron,
    output logic                                 dout_valid,
    input  logic                                 dout_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACC, OUTPUT} state_t;

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     beat, beat_last;
    logic [NEURON_WIDTH-1:0]   neuron, neuron_last;
    logic [BRAM_LAT-1:0]       en_sr, last_sr;
    logic                      issue, issue_last, accept, final_neuron;

    assign issue        = (state == ISSUE);
    assign issue_last   = issue && (beat == beat_last);
    assign accept       = (state == OUTPUT) && dout_valid && dout_ready;
    assign final_neuron = (neuron == neuron_last);

    assign busy      = (state != IDLE);
    assign in_addr   = beat;
    assign w_addr    = {neuron, beat};
    assign macc_din1 = in_data;
    assign macc_din2 = w_data;
    assign macc_en   = en_sr[BRAM_LAT-1];
    assign macc_last = last_sr[BRAM_LAT-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ISSUE;
            ISSUE:    if (issue_last) state_nxt = WAIT_ACC;
            WAIT_ACC: if (macc_valid) state_nxt = OUTPUT;
            OUTPUT:   if (accept) state_nxt = final_neuron ? IDLE : ISSUE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            beat_last   <= '0;
            neuron      <= '0;
            neuron_last <= '0;
            en_sr       <= '0;
            last_sr     <= '0;
            macc_rst    <= 1'b1;
            done        <= 1'b0;
            dout        <= '0;
            dout_neuron <= '0;
            dout_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Strobes ride alongside the read so they meet the returning data.
            en_sr    <= BRAM_LAT'({en_sr, issue});
            last_sr  <= BRAM_LAT'({last_sr, issue_last});
            macc_rst <= (state_nxt == IDLE);
            done     <= accept && final_neuron;
            case (state)
                IDLE: begin
                    if (start) begin
                        // A count of zero still runs one beat / one neuron.
                        beat_last   <= (n_words == '0) ? '0 : n_words - 1'b1;
                        neuron_last <= (n_neurons == '0) ? '0 : n_neurons - 1'b1;
                        beat        <= '0;
                        neuron      <= '0;
                    end
                end
                ISSUE: begin
                    if (!issue_last) beat <= beat + 1'b1;
                end
                WAIT_ACC: begin
                    if (macc_valid) begin
                        dout        <= macc_dout;
                        dout_neuron <= neuron;
                        dout_valid  <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (accept) begin
                        dout_valid <= 1'b0;
                        if (!final_neuron) begin
                            neuron <= neuron + 1'b1;
                            beat   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: BRAM and MACC stand-ins around the DUT, with each
// neuron's result predicted directly as a dot product over the BRAM contents.
module tb_neuron_seq;

    localparam int PI  = 4;
    localparam int D1  = 16;
    localparam int D2  = 16;
    localparam int AW  = 10;
    localparam int NW  = 6;
    localparam int L   = 2;
    localparam int DW  = 32;
    localparam int BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [AW-1:0]        n_words = '0;
    logic [NW-1:0]        n_neurons = '0;
    logic                 busy, done;
    logic [AW-1:0]        in_addr;
    logic [NW+AW-1:0]     w_addr;
    logic [PI*D1-1:0]     in_data, macc_din1;
    logic [PI*D2-1:0]     w_data, macc_din2;
    logic                 macc_en, macc_last, macc_rst;
    logic [DW-1:0]        macc_dout;
    logic                 macc_valid;
    logic [DW-1:0]        dout;
    logic [NW-1:0]        dout_neuron;
    logic                 dout_valid;
    logic                 dout_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int seed    = 0;
    bit ones_mode = 1'b0;
    bit spur    = 1'b0;

    neuron_seq #(
        .PARALLEL_IN(PI), .DATA1_WIDTH(D1), .DATA2_WIDTH(D2), .ADDR_WIDTH(AW),
        .NEURON_WIDTH(NW), .BRAM_LAT(L), .DOUT_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_words(n_words), .n_neurons(n_neurons),
        .busy(busy), .done(done), .in_addr(in_addr), .w_addr(w_addr),
        .in_data(in_data), .w_data(w_data), .macc_din1(macc_din1), .macc_din2(macc_din2),
        .macc_en(macc_en), .macc_last(macc_last), .macc_rst(macc_rst),
        .macc_dout(macc_dout), .macc_valid(macc_valid),
        .dout(dout), .dout_neuron(dout_neuron), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] in_lane(input logic [AW-1:0] a, input int lane,
                                            input int sd, input bit ones);
        if (ones) return 16'd1;
        return 16'((int'(a) * 37 + lane * 11 + sd) & 8'hFF);
    endfunction

    function automatic logic [15:0] w_lane(input logic [NW+AW-1:0] a, input int lane,
                                           input int sd, input bit ones);
        if (ones) return 16'd1;
        return 16'(((int'(a) * 53 + lane * 29 + (sd >> 4)) ^ (int'(a) >> 3)) & 8'hFF);
    endfunction

    // Expected result: plain dot product of the input vector with row n.
    function automatic logic [DW-1:0] model_result(input int n, input int nw_e,
                                                   input int sd, input bit ones);
        logic [DW-1:0] s;
        s = '0;
        for (int b = 0; b < nw_e; b++)
            for (int l = 0; l < PI; l++)
                s += DW'(in_lane(AW'(b), l, sd, ones)) *
                     DW'(w_lane({NW'(n), AW'(b)}, l, sd, ones));
        return s;
    endfunction

    // BRAM stand-ins with L cycles of read latency.
    logic [AW-1:0]    ia_p1, ia_p2;
    logic [NW+AW-1:0] wa_p1, wa_p2;
    always @(posedge clk) begin
        ia_p1 <= in_addr; ia_p2 <= ia_p1;
        wa_p1 <= w_addr;  wa_p2 <= wa_p1;
    end
    always_comb begin
        in_data = '0;
        w_data  = '0;
        for (int l = 0; l < PI; l++) begin
            in_data[l*D1 +: D1] = in_lane(ia_p2, l, seed, ones_mode);
            w_data[l*D2 +: D2]  = w_lane(wa_p2, l, seed, ones_mode);
        end
    end

    // MACC stand-in: accumulate beats, emit the sum a random 1..4 cycles after last.
    logic [DW-1:0] acc, mres, beat_dot;
    logic [2:0]    mcnt;
    logic          stub_valid;
    always_comb begin
        beat_dot = '0;
        for (int l = 0; l < PI; l++)
            beat_dot += DW'(macc_din1[l*D1 +: D1]) * DW'(macc_din2[l*D2 +: D2]);
    end
    always @(posedge clk) begin
        if (rst || macc_rst) begin
            acc  <= '0;
            mcnt <= '0;
        end else begin
            if (mcnt != 3'd0) mcnt <= mcnt - 3'd1;
            if (macc_en) begin
                if (macc_last) begin
                    mres <= acc + beat_dot;
                    acc  <= '0;
                    mcnt <= 3'($urandom_range(1, 4));
                end else begin
                    acc <= acc + beat_dot;
                end
            end
        end
    end
    assign stub_valid = (mcnt == 3'd1);
    assign macc_valid = stub_valid | spur;
    assign macc_dout  = stub_valid ? mres : 32'hDEAD_BEEF;

    // poke: 0 none, 1 second start + n_words change at rel 2, 2 spurious valid at rel 2
    task automatic run_job(input int nw, input int nn, input int stall, input int poke, input bit ones);
        int nw_e, nn_e, t0, rel, beats, lasts, dones, n_exp, vcnt, cur_stall;
        bit fin, done_due, next_first, seen_en, prev_hold, pend_dv;
        logic [DW-1:0] prev_dout;
        logic [NW-1:0] prev_nrn;
        nw_e = (nw == 0) ? 1 : nw;
        nn_e = (nn == 0) ? 1 : nn;
        beats = 0; lasts = 0; dones = 0; n_exp = 0; vcnt = 0; cur_stall = 0;
        fin = 0; done_due = 0; next_first = 0; seen_en = 0; prev_hold = 0; pend_dv = 0;
        prev_dout = '0; prev_nrn = '0;
        @(negedge clk);
        seed = ones ? 0 : int'($urandom_range(0, 4095));
        ones_mode = ones;
        n_words = AW'(nw);
        n_neurons = NW'(nn);
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < BUDGET && !fin; i++) begin
            @(negedge clk);
            start = 1'b0;
            spur = 1'b0;
            dout_ready = 1'b0;
            rel = cyc - t0;
            if (rel == 1) chk("busy_c1", busy, 1);
            if (n_exp == 0 && rel >= 1 && rel <= nw_e) begin
                chk("in_addr", in_addr, rel - 1);
                chk("w_addr_n0", w_addr, rel - 1);
            end
            if (next_first) begin
                chk("next_in_addr", in_addr, 0);
                chk("next_w_addr", w_addr, {NW'(n_exp), AW'(0)});
                next_first = 0;
            end
            if (pend_dv) chk("dv_latency", dout_valid, 1);
            pend_dv = stub_valid;
            if (done) dones++;
            if (done_due) begin
                chk("done", done, 1);
                chk("busy_at_done", busy, 0);
                fin = 1;
            end
            if (macc_en) begin
                beats++;
                if (!seen_en) begin
                    seen_en = 1;
                    chk("first_en", rel, 1 + L);
                end
            end
            if (macc_last) begin
                chk("last_with_en", macc_en, 1);
                if (lasts == 0) chk("last_cycle", rel, nw_e + L);
                lasts++;
            end
            if (prev_hold) begin
                chk("stall_valid", dout_valid, 1);
                chk("stall_dout", dout, prev_dout);
                chk("stall_neuron", dout_neuron, prev_nrn);
            end
            prev_hold = 0;
            if (dout_valid && !fin) begin
                vcnt++;
                if (vcnt == 1) cur_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                if (vcnt > cur_stall) begin
                    dout_ready = 1'b1;
                    chk("dout", dout, model_result(n_exp, nw_e, seed, ones));
                    chk("dout_neuron", dout_neuron, n_exp);
                    n_exp++;
                    vcnt = 0;
                    if (n_exp == nn_e) done_due = 1;
                    else next_first = 1;
                end else begin
                    prev_hold = 1;
                    prev_dout = dout;
                    prev_nrn = dout_neuron;
                end
            end
            if (rel == 2 && poke == 1) begin
                start = 1'b1;
                n_words = AW'(nw + 3);
            end
            if (rel == 2 && poke == 2) spur = 1'b1;
            if (rel == 3 && poke == 2) begin
                chk("spur_issue_dv", dout_valid, 0);
                chk("spur_issue_busy", busy, 1);
            end
        end
        chk("complete", fin, 1);
        chk("results", n_exp, nn_e);
        chk("beats", beats, nw_e * nn_e);
        chk("lasts", lasts, nn_e);
        @(negedge clk);
        if (done) dones++;
        chk("done_once", dones, 1);
        chk("idle_busy", busy, 0);
        chk("idle_macc_rst", macc_rst, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", macc_en, 0);
        chk("rst_last", macc_last, 0);
        chk("rst_dv", dout_valid, 0);
        chk("rst_macc_rst", macc_rst, 1);
        chk("rst_dout", dout, 0);
        chk("rst_neuron", dout_neuron, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_idle_dv", dout_valid, 0);
        chk("spur_idle_busy", busy, 0);

        run_job(3, 1, 0, 0, 1'b1);
        run_job(4, 3, 5, 0, 1'b0);
        run_job(0, 0, 0, 0, 1'b0);
        run_job(5, 2, -1, 1, 1'b0);
        run_job(6, 1, -1, 2, 1'b0);

        @(negedge clk);
        n_words = 6; n_neurons = 2; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_addr", in_addr, 2);
        chk("pre_rst_en", macc_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_en", macc_en, 0);
        chk("mid_rst_macc_rst", macc_rst, 1);
        chk("mid_rst_dv", dout_valid, 0);
        chk("mid_rst_addr", in_addr, 0);
        @(negedge clk);
        chk("post_rst_en", macc_en, 0);
        chk("post_rst_busy", busy, 0);
        run_job(6, 2, 0, 0, 1'b0);

        for (int j = 0; j < 12; j++)
            run_job(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)), -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
